// File: rtl/hazard_scoreboard.sv
// Register scoreboard for ID-stage hazard detection: one countdown timer per
// architectural register drives stall/issue, forwarding distance, WAW protection and EX-flush rollback.
module hazard_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3,
    parameter int LAT_W    = 3,
    parameter int MAX_FWD  = 2,
    parameter int CNT_W    = 16,
    parameter int R0_ZERO  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic                id_rs_used,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_rt_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_reg_write,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                flush_id,
    input  logic                flush_ex,
    output logic                stall,
    output logic                issue,
    output logic [LAT_W-1:0]    fwd_a,
    output logic [LAT_W-1:0]    fwd_b,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [LAT_W-1:0]  MAX_FWD_L  = LAT_W'(MAX_FWD);
    localparam logic [LAT_W-1:0]  ONE_L      = LAT_W'(1);
    localparam logic [REG_AW:0]   NUM_REGS_L = (REG_AW+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][LAT_W-1:0] timer_reg, timer_next;
    logic                last_valid_reg, last_valid_next;
    logic [REG_AW-1:0]   last_rd_reg, last_rd_next;
    logic [LAT_W-1:0]    shadow_reg, shadow_next;
    logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;

    logic                rs_tracked, rt_tracked, rd_tracked;
    logic [LAT_W-1:0]    t_rs, t_rt, t_rd, eff_lat;
    logic                rs_hot, rt_hot, raw_hz, waw_hz, wr_issue;

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] t);
        return (t == '0) ? '0 : t - ONE_L;
    endfunction

    // Out-of-range addresses and a hardwired r0 are never tracked.
    function automatic logic is_tracked(input logic [REG_AW-1:0] a);
        return ({1'b0, a} < NUM_REGS_L) && !((R0_ZERO != 0) && (a == '0));
    endfunction

    assign rs_tracked = is_tracked(id_rs);
    assign rt_tracked = is_tracked(id_rt);
    assign rd_tracked = is_tracked(id_rd);
    assign t_rs       = rs_tracked ? timer_reg[id_rs] : '0;
    assign t_rt       = rt_tracked ? timer_reg[id_rt] : '0;
    assign t_rd       = rd_tracked ? timer_reg[id_rd] : '0;
    assign eff_lat    = (id_lat == '0) ? ONE_L : id_lat;

    assign rs_hot   = id_rs_used && rs_tracked;
    assign rt_hot   = id_rt_used && rt_tracked;
    assign raw_hz   = (rs_hot && (t_rs > MAX_FWD_L)) || (rt_hot && (t_rt > MAX_FWD_L));
    // A younger write may not land before an older one to the same register.
    assign waw_hz   = id_reg_write && rd_tracked && (t_rd > eff_lat);
    assign stall    = id_valid && !flush_id && (raw_hz || waw_hz);
    assign issue    = id_valid && !flush_id && !stall;
    assign wr_issue = issue && id_reg_write && rd_tracked;

    assign fwd_a     = (rs_hot && (t_rs <= MAX_FWD_L)) ? t_rs : '0;
    assign fwd_b     = (rt_hot && (t_rt <= MAX_FWD_L)) ? t_rt : '0;
    assign stall_cnt = stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_timer
            assign busy_mask[gi] = |timer_reg[gi];
            // New issue beats rollback, which beats the plain countdown.
            assign timer_next[gi] =
                (wr_issue && (id_rd == REG_AW'(gi)))                     ? eff_lat :
                (flush_ex && last_valid_reg && (last_rd_reg == REG_AW'(gi))) ? sat_dec(shadow_reg) :
                                                                           sat_dec(timer_reg[gi]);
        end
    endgenerate

    always_comb begin
        last_valid_next = wr_issue;
        last_rd_next    = last_rd_reg;
        shadow_next     = shadow_reg;
        stall_cnt_next  = stall_cnt_reg;
        if (wr_issue) begin
            last_rd_next = id_rd;
            shadow_next  = sat_dec(t_rd);
        end
        if (stall && !(&stall_cnt_reg))
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_reg      <= '0;
            last_valid_reg <= 1'b0;
            last_rd_reg    <= '0;
            shadow_reg     <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            timer_reg      <= timer_next;
            last_valid_reg <= last_valid_next;
            last_rd_reg    <= last_rd_next;
            shadow_reg     <= shadow_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// compared against a completion-cycle model of in-flight register writes.
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;
    localparam int LAT_W    = 3;
    localparam int MAX_FWD  = 2;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, id_valid, id_rs_used, id_rt_used, id_reg_write, flush_id, flush_ex;
    logic [REG_AW-1:0]   id_rs, id_rt, id_rd;
    logic [LAT_W-1:0]    id_lat;
    logic                stall, issue;
    logic [LAT_W-1:0]    fwd_a, fwd_b;
    logic [NUM_REGS-1:0] busy_mask;
    logic [CNT_W-1:0]    stall_cnt;

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LAT_W(LAT_W),
        .MAX_FWD(MAX_FWD), .CNT_W(CNT_W), .R0_ZERO(1)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .stall(stall), .issue(issue), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: each register remembers the absolute cycle its pending write lands.
    int cyc = 0;
    int done_c[NUM_REGS];
    int prev_done = 0;
    bit m_lv = 0;
    int m_lr = 0;
    int m_cnt = 0;
    int e_stall, e_issue, e_fa, e_fb;
    logic [NUM_REGS-1:0] e_busy;

    function automatic int remaining(int r);
        return (done_c[r] > cyc) ? done_c[r] - cyc : 0;
    endfunction

    function automatic bit trk(int r);
        return r != 0;
    endfunction

    function automatic int eff_l();
        return (id_lat == 0) ? 1 : int'(id_lat);
    endfunction

    task automatic model_eval();
        int ta, tb_t;
        bit raw, waw;
        ta   = remaining(int'(id_rs));
        tb_t = remaining(int'(id_rt));
        e_fa = (id_rs_used && trk(int'(id_rs)) && ta <= MAX_FWD) ? ta : 0;
        e_fb = (id_rt_used && trk(int'(id_rt)) && tb_t <= MAX_FWD) ? tb_t : 0;
        raw  = (id_rs_used && trk(int'(id_rs)) && ta > MAX_FWD) ||
               (id_rt_used && trk(int'(id_rt)) && tb_t > MAX_FWD);
        waw  = id_reg_write && trk(int'(id_rd)) && remaining(int'(id_rd)) > eff_l();
        e_stall = (id_valid && !flush_id && (raw || waw)) ? 1 : 0;
        e_issue = (id_valid && !flush_id && e_stall == 0) ? 1 : 0;
        for (int r = 0; r < NUM_REGS; r++) e_busy[r] = remaining(r) > 0;
    endtask

    task automatic tick();
        int old_rd_done;
        model_eval();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) done_c[r] = 0;
            m_lv = 0;
            m_cnt = 0;
        end else begin
            old_rd_done = done_c[int'(id_rd)];
            if (e_stall != 0 && m_cnt < 65535) m_cnt++;
            if (flush_ex && m_lv) done_c[m_lr] = prev_done;
            if (e_issue != 0 && id_reg_write && trk(int'(id_rd))) begin
                prev_done = old_rd_done;
                done_c[int'(id_rd)] = cyc + 1 + eff_l();
                m_lv = 1;
                m_lr = int'(id_rd);
            end else begin
                m_lv = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
        id_rd = 0; id_reg_write = 0; id_lat = 0; flush_id = 0; flush_ex = 0;
    endtask

    task automatic idle(int n);
        clr();
        repeat (n) tick();
    endtask

    task automatic do_write(int rd, int lat);
        clr();
        id_valid = 1; id_rd = REG_AW'(rd); id_reg_write = 1; id_lat = LAT_W'(lat);
    endtask

    task automatic test_reset();
        do_write(3, 5); #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_pre_issue: got %b want 1", issue); end
        tick();
        clr(); id_valid = 1; id_rs = 3; id_rs_used = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_pre_stall: got %b want 1", stall); end
        tick();
        rst = 1; tick(); tick(); rst = 0; #1;
        checks++; if (busy_mask !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_mask); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_r3_gone: got issue %b want 1", issue); end
        $display("test_reset: busy=%b stall=%b cnt=%0d", busy_mask, stall, stall_cnt);
        idle(8);
    endtask

    task automatic test_alu_fwd();
        do_write(3, 2); tick();
        clr(); id_valid = 1; id_rs = 3; id_rs_used = 1; #1;
        checks++; if (fwd_a !== 3'd2 || stall !== 1'b0) begin errors++; $display("FAIL alu_t1: got fwd_a=%0d stall=%b want 2/0", fwd_a, stall); end
        tick(); #1;
        checks++; if (fwd_a !== 3'd1) begin errors++; $display("FAIL alu_t2: got fwd_a=%0d want 1", fwd_a); end
        tick(); #1;
        checks++; if (fwd_a !== 3'd0 || busy_mask[3] !== 1'b0) begin errors++; $display("FAIL alu_t3: got fwd_a=%0d busy3=%b want 0/0", fwd_a, busy_mask[3]); end
        $display("test_alu_fwd: final fwd_a=%0d busy=%b", fwd_a, busy_mask);
        idle(8);
    endtask

    task automatic test_load_use();
        int cnt0;
        do_write(5, 3); tick();
        cnt0 = int'(stall_cnt);
        clr(); id_valid = 1; id_rt = 5; id_rt_used = 1; #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL load_t1: got stall=%b issue=%b want 1/0", stall, issue); end
        tick(); #1;
        checks++; if (stall !== 1'b0 || fwd_b !== 3'd2 || issue !== 1'b1) begin errors++; $display("FAIL load_t2: got stall=%b fwd_b=%0d issue=%b want 0/2/1", stall, fwd_b, issue); end
        checks++; if (int'(stall_cnt) != cnt0 + 1) begin errors++; $display("FAIL load_cnt: got %0d want %0d", stall_cnt, cnt0 + 1); end
        $display("test_load_use: stall_cnt=%0d", stall_cnt);
        idle(8);
    endtask

    task automatic test_waw();
        do_write(2, 3); tick();
        do_write(2, 1); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_t1: got stall=%b want 1", stall); end
        tick(); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_t2: got stall=%b want 1", stall); end
        tick(); #1;
        checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL waw_t3: got issue=%b stall=%b want 1/0", issue, stall); end
        tick();
        clr(); id_rs = 2; id_rs_used = 1; #1;
        checks++; if (fwd_a !== 3'd1) begin errors++; $display("FAIL waw_t4: got timer=%0d want 1", fwd_a); end
        $display("test_waw: r2 timer at t4=%0d", fwd_a);
        idle(8);
    endtask

    task automatic test_flush_rollback();
        do_write(4, 3); tick();
        do_write(4, 3); #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL flush_t1: got issue=%b want 1", issue); end
        tick();
        clr(); flush_ex = 1; tick();
        clr(); id_rs = 4; id_rs_used = 1; #1;
        checks++; if (fwd_a !== 3'd1) begin errors++; $display("FAIL flush_t3: got timer=%0d want 1", fwd_a); end
        tick(); #1;
        checks++; if (busy_mask[4] !== 1'b0) begin errors++; $display("FAIL flush_t4: got busy4=%b want 0", busy_mask[4]); end
        $display("test_flush_rollback: busy=%b", busy_mask);
        idle(8);
    endtask

    task automatic test_r0_flush_id();
        int cnt0;
        do_write(0, 3); tick();
        clr(); id_valid = 1; id_rs = 0; id_rs_used = 1; #1;
        checks++; if (stall !== 1'b0 || fwd_a !== 3'd0 || busy_mask !== '0) begin errors++; $display("FAIL r0_consumer: got stall=%b fwd_a=%0d busy=%b want 0/0/0", stall, fwd_a, busy_mask); end
        tick();
        do_write(6, 4); tick();
        cnt0 = int'(stall_cnt);
        clr(); id_valid = 1; id_rs = 6; id_rs_used = 1; flush_id = 1; #1;
        checks++; if (stall !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL flush_id: got stall=%b issue=%b want 0/0", stall, issue); end
        tick(); clr(); #1;
        checks++; if (int'(stall_cnt) != cnt0) begin errors++; $display("FAIL flush_id_cnt: got %0d want %0d", stall_cnt, cnt0); end
        $display("test_r0_flush_id: stall_cnt=%0d", stall_cnt);
        idle(8);
    endtask

    task automatic test_random(int n);
        for (int i = 0; i < n; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rs        = REG_AW'($urandom_range(0, NUM_REGS - 1));
            id_rt        = REG_AW'($urandom_range(0, NUM_REGS - 1));
            id_rd        = REG_AW'($urandom_range(0, NUM_REGS - 1));
            id_rs_used   = $urandom_range(0, 1) == 1;
            id_rt_used   = $urandom_range(0, 1) == 1;
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_lat       = LAT_W'($urandom_range(0, 5));
            flush_id     = ($urandom_range(0, 9) == 0);
            flush_ex     = ($urandom_range(0, 4) == 0);
            #1;
            model_eval();
            checks++;
            if (stall !== e_stall[0] || issue !== e_issue[0] || int'(fwd_a) != e_fa ||
                int'(fwd_b) != e_fb || busy_mask !== e_busy || int'(stall_cnt) != m_cnt) begin
                errors++;
                $display("FAIL random_%0d: got st=%b is=%b fa=%0d fb=%0d busy=%b cnt=%0d want st=%0d is=%0d fa=%0d fb=%0d busy=%b cnt=%0d",
                         i, stall, issue, fwd_a, fwd_b, busy_mask, stall_cnt,
                         e_stall, e_issue, e_fa, e_fb, e_busy, m_cnt);
            end
            $display("rand %0d: v=%b rs=%0d/%b rt=%0d/%b rd=%0d/%b lat=%0d fid=%b fex=%b rst=%b -> st=%b is=%b fa=%0d fb=%0d busy=%b",
                     i, id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_reg_write,
                     id_lat, flush_id, flush_ex, rst, stall, issue, fwd_a, fwd_b, busy_mask);
            tick();
        end
        rst = 0;
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) done_c[r] = 0;
        clr();
        rst = 1;
        tick(); tick();
        rst = 0;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_waw();
        test_flush_rollback();
        test_r0_flush_id();
        test_random(250);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
